// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, trap flush/redirect and debug halt.
// Debug halt/drain states are built only with PIPE_CTRL_DEBUG_HALT_EN.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic        clk_i,
  input  logic        n_rst_i,
  input  logic        stallreq_if_i,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_pc_i,
  input  logic        dbg_halt_req_i,
  input  logic        dbg_resume_req_i,
  output logic [5:0]  stall_o,
  output logic        flush_o,
  output logic        ctrl_redirect_pc_o,
  output logic [31:0] redirect_pc_o,
  output logic        trap_ack_o,
  output logic        dbg_halted_o
);

  localparam logic [2:0] FL = 3'(FLUSH_CYCLES);

`ifdef PIPE_CTRL_DEBUG_HALT_EN
  localparam logic [3:0] DL = 4'(DRAIN_CYCLES);

  typedef enum logic [1:0] {
    RUN, FLUSH, DRAIN, HALTED
  } state_t;

  logic [3:0] dcnt, dcnt_nx;
`else
  typedef enum logic {
    RUN, FLUSH
  } state_t;

  logic unused_dbg;
  assign unused_dbg = dbg_halt_req_i
                    ^ dbg_resume_req_i;
`endif

  state_t      state, state_nx;
  logic [2:0]  fcnt, fcnt_nx;
  logic [5:0]  run_vec;
  logic        take;

  // Oldest stalled stage freezes itself and everything behind it.
  always_comb begin
    run_vec = 6'b000000;
    priority case (1'b1)
      stallreq_mem_i: run_vec = 6'b011111;
      stallreq_ex_i:  run_vec = 6'b001111;
      stallreq_id_i:  run_vec = 6'b000111;
      stallreq_if_i:  run_vec = 6'b000011;
      default:        run_vec = 6'b000000;
    endcase
  end

  assign take = trap_req_i & ~stallreq_mem_i;

  always_comb begin
    state_nx           = state;
    fcnt_nx            = fcnt;
    stall_o            = 6'b000000;
    flush_o            = 1'b0;
    ctrl_redirect_pc_o = 1'b0;
    trap_ack_o         = 1'b0;
`ifdef PIPE_CTRL_DEBUG_HALT_EN
    dcnt_nx            = dcnt;
`endif
    case (state)
      RUN: begin
        stall_o = run_vec;
        if (take) begin
          trap_ack_o = 1'b1;
          state_nx   = FLUSH;
          fcnt_nx    = FL;
        end
`ifdef PIPE_CTRL_DEBUG_HALT_EN
        else if (dbg_halt_req_i) begin
          state_nx = DRAIN;
          dcnt_nx  = DL;
        end
`endif
      end
      FLUSH: begin
        flush_o            = 1'b1;
        ctrl_redirect_pc_o = (fcnt == FL);
        fcnt_nx            = fcnt - 3'd1;
        if (fcnt == 3'd1) begin
          state_nx = RUN;
        end
      end
`ifdef PIPE_CTRL_DEBUG_HALT_EN
      DRAIN: begin
        stall_o = stallreq_mem_i ? run_vec
                                 : 6'b000011;
        if (take) begin
          trap_ack_o = 1'b1;
          state_nx   = FLUSH;
          fcnt_nx    = FL;
        end else if (!stallreq_mem_i) begin
          dcnt_nx = dcnt - 4'd1;
          if (dcnt == 4'd1) begin
            state_nx = HALTED;
          end
        end
      end
      HALTED: begin
        stall_o = 6'b111111;
        if (dbg_resume_req_i) begin
          state_nx = RUN;
        end
      end
`endif
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state         <= RUN;
      fcnt          <= 3'd0;
      redirect_pc_o <= 32'h0;
`ifdef PIPE_CTRL_DEBUG_HALT_EN
      dcnt          <= 4'd0;
`endif
    end else begin
      state <= state_nx;
      fcnt  <= fcnt_nx;
`ifdef PIPE_CTRL_DEBUG_HALT_EN
      dcnt  <= dcnt_nx;
`endif
      if (trap_ack_o) begin
        redirect_pc_o <= trap_pc_i;
      end
    end
  end

`ifdef PIPE_CTRL_DEBUG_HALT_EN
  assign dbg_halted_o = (state == HALTED);
`else
  assign dbg_halted_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed plan plus random run vs a cycle-window model.
// Two instances: FLUSH_CYCLES=1 (index 0) and FLUSH_CYCLES=3 (index 1).
module tb_pipe_ctrl;

  localparam int DR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        n_rst;
  logic        s_if, s_id, s_ex, s_mem;
  logic        trap, halt, resume;
  logic [31:0] tpc;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b;
  logic        redir_a, redir_b;
  logic [31:0] rpc_a, rpc_b;
  logic        ack_a, ack_b;
  logic        hlt_a, hlt_b;

  pipe_ctrl #(.FLUSH_CYCLES(1), .DRAIN_CYCLES(DR)) dut (
    .clk_i(clk), .n_rst_i(n_rst),
    .stallreq_if_i(s_if), .stallreq_id_i(s_id),
    .stallreq_ex_i(s_ex), .stallreq_mem_i(s_mem),
    .trap_req_i(trap), .trap_pc_i(tpc),
    .dbg_halt_req_i(halt), .dbg_resume_req_i(resume),
    .stall_o(stall_a), .flush_o(flush_a),
    .ctrl_redirect_pc_o(redir_a), .redirect_pc_o(rpc_a),
    .trap_ack_o(ack_a), .dbg_halted_o(hlt_a)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .DRAIN_CYCLES(DR)) dut3 (
    .clk_i(clk), .n_rst_i(n_rst),
    .stallreq_if_i(s_if), .stallreq_id_i(s_id),
    .stallreq_ex_i(s_ex), .stallreq_mem_i(s_mem),
    .trap_req_i(trap), .trap_pc_i(tpc),
    .dbg_halt_req_i(halt), .dbg_resume_req_i(resume),
    .stall_o(stall_b), .flush_o(flush_b),
    .ctrl_redirect_pc_o(redir_b), .redirect_pc_o(rpc_b),
    .trap_ack_o(ack_b), .dbg_halted_o(hlt_b)
  );

  int nchk = 0;
  int nerr = 0;

  // Model: flush is a window of cycle numbers; drain counts progress.
  int          cyc;
  int          fstart [2];
  bit          drn    [2];
  int          prog   [2];
  bit          hld    [2];
  logic [31:0] mrpc   [2];

  function automatic int fl(int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [5:0] prio_vec();
    if (s_mem)     return 6'h1f;
    else if (s_ex) return 6'h0f;
    else if (s_id) return 6'h07;
    else if (s_if) return 6'h03;
    else           return 6'h00;
  endfunction

  function automatic bit in_fl(int i);
    return cyc >= fstart[i] && cyc < fstart[i] + fl(i);
  endfunction

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] want);
    nchk++;
    assert (obs === want) else begin
      nerr++;
      $error("FAIL %s got %h want %h", tag, obs, want);
    end
  endtask

  task automatic model_rst();
    for (int i = 0; i < 2; i++) begin
      fstart[i] = -100;
      drn[i]    = 1'b0;
      prog[i]   = 0;
      hld[i]    = 1'b0;
      mrpc[i]   = 32'h0;
    end
  endtask

  task automatic check_inst(int i, logic [5:0] s, logic f,
                            logic r, logic [31:0] p,
                            logic a, logic h);
    logic [5:0] ws;
    logic       wf, wr, wa;
    ws = prio_vec(); wf = 0; wr = 0;
    wa = trap && !s_mem;
    if (in_fl(i)) begin
      ws = 0; wf = 1; wr = (cyc == fstart[i]); wa = 0;
    end else if (hld[i]) begin
      ws = 6'h3f; wa = 0;
    end else if (drn[i] && !s_mem) begin
      ws = 6'h03;
    end
    chk($sformatf("i%0d.stall", i), 32'(s), 32'(ws));
    chk($sformatf("i%0d.flush", i), 32'(f), 32'(wf));
    chk($sformatf("i%0d.redir", i), 32'(r), 32'(wr));
    chk($sformatf("i%0d.rpc", i), p, mrpc[i]);
    chk($sformatf("i%0d.ack", i), 32'(a), 32'(wa));
    chk($sformatf("i%0d.halted", i), 32'(h), 32'(hld[i]));
  endtask

  task automatic model_clk();
    for (int i = 0; i < 2; i++) begin
      if (in_fl(i)) begin
      end else if (hld[i]) begin
        if (resume) hld[i] = 1'b0;
      end else if (trap && !s_mem) begin
        mrpc[i]   = tpc;
        fstart[i] = cyc + 1;
        drn[i]    = 1'b0;
      end else if (drn[i]) begin
        if (!s_mem) prog[i]++;
        if (prog[i] == DR) begin
          drn[i] = 1'b0;
          hld[i] = 1'b1;
        end
      end else begin
`ifdef PIPE_CTRL_DEBUG_HALT_EN
        if (halt) begin
          drn[i]  = 1'b1;
          prog[i] = 0;
        end
`endif
      end
    end
    cyc++;
  endtask

  task automatic look();
    @(negedge clk);
    check_inst(0, stall_a, flush_a, redir_a, rpc_a,
               ack_a, hlt_a);
    check_inst(1, stall_b, flush_b, redir_b, rpc_b,
               ack_b, hlt_b);
  endtask

  task automatic adv();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic step();
    look();
    adv();
  endtask

  task automatic idle();
    s_if = 0; s_id = 0; s_ex = 0; s_mem = 0;
    trap = 0; halt = 0; resume = 0; tpc = 32'h0;
  endtask

  initial begin
    idle();
    n_rst = 1'b0;
    cyc   = 0;
    model_rst();
    #12;
    chk("rst.stall", 32'(stall_a), 32'h0);
    chk("rst.flush", 32'(flush_a), 32'h0);
    chk("rst.rpc", rpc_a, 32'h0);
    chk("rst.halted", 32'(hlt_b), 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    adv();
    step();

    // Priority merge
    s_id = 1; s_ex = 1;
    look(); chk("prio.idex", 32'(stall_a), 32'h0f); adv();
    s_mem = 1;
    look(); chk("prio.mem", 32'(stall_a), 32'h1f); adv();
    idle(); step();

    // Trap with one flush cycle
    trap = 1; tpc = 32'h0000_0100;
    look(); chk("trap.ack", 32'(ack_a), 32'h1); adv();
    trap = 0;
    look();
    chk("trap.flush", 32'(flush_a), 32'h1);
    chk("trap.redir", 32'(redir_a), 32'h1);
    chk("trap.rpc", rpc_a, 32'h100);
    adv();
    look();
    chk("trap.n2flush", 32'(flush_a), 32'h0);
    chk("trap.n2redir", 32'(redir_a), 32'h0);
    chk("trap.n2ack", 32'(ack_a), 32'h0);
    adv();
    repeat (3) step();

    // Trap blocked by memory wait
    trap = 1; s_mem = 1; tpc = 32'h0000_0200;
    for (int k = 0; k < 3; k++) begin
      look();
      chk("blk.ack", 32'(ack_a), 32'h0);
      chk("blk.stall", 32'(stall_a), 32'h1f);
      adv();
    end
    s_mem = 0;
    look(); chk("blk.late_ack", 32'(ack_a), 32'h1); adv();
    trap = 0;
    repeat (4) step();

    // Async reset in the second flush cycle of the 3-cycle instance
    trap = 1; tpc = 32'h0000_0300;
    step();
    trap = 0;
    step();
    #1;
    chk("rstf.pre", 32'(flush_b), 32'h1);
    n_rst = 1'b0;
    #1;
    chk("rstf.flush", 32'(flush_b), 32'h0);
    chk("rstf.rpc", rpc_b, 32'h0);
    model_rst();
    @(negedge clk);
    n_rst = 1'b1;
    adv();
    look(); chk("rstf.run", 32'(flush_b), 32'h0); adv();
    s_id = 1;
    look(); chk("rstf.stall", 32'(stall_b), 32'h07); adv();
    idle(); step();

`ifdef PIPE_CTRL_DEBUG_HALT_EN
    // Halt, drain, resume
    halt = 1;
    step();
    halt = 0;
    for (int k = 0; k < DR; k++) begin
      look(); chk("drain.stall", 32'(stall_a), 32'h03); adv();
    end
    look();
    chk("halt.stall", 32'(stall_a), 32'h3f);
    chk("halt.flag", 32'(hlt_a), 32'h1);
    adv();
    trap = 1;
    look(); chk("halt.noack", 32'(ack_a), 32'h0); adv();
    trap = 0; resume = 1;
    step();
    resume = 0;
    look();
    chk("resume.flag", 32'(hlt_a), 32'h0);
    chk("resume.stall", 32'(stall_a), 32'h0);
    adv();

    // Trap and halt together, then trap during drain
    trap = 1; halt = 1; tpc = 32'h0000_0400;
    look(); chk("th.ack", 32'(ack_a), 32'h1); adv();
    trap = 0;
    look(); chk("th.flush", 32'(flush_a), 32'h1); adv();
    step();
    look(); chk("th.drain", 32'(stall_a), 32'h03); adv();
    trap = 1; tpc = 32'h0000_0500;
    look(); chk("th.drain_ack", 32'(ack_a), 32'h1); adv();
    trap = 0; halt = 0;
    repeat (8) step();
    resume = 1;
    repeat (2) step();
    idle();
`endif

    // Randomized run against the model
    for (int k = 0; k < 600; k++) begin
      s_if   = ($urandom_range(3) == 0);
      s_id   = ($urandom_range(3) == 0);
      s_ex   = ($urandom_range(4) == 0);
      s_mem  = ($urandom_range(3) == 0);
      trap   = ($urandom_range(5) == 0);
      tpc    = $urandom;
      halt   = ($urandom_range(7) == 0);
      resume = ($urandom_range(5) == 0);
      step();
    end
    idle();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             nchk, nerr);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the 5-stage core. It merges per-stage stall requests into the 6-bit stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It also sequences trap redirection, which flushes the pipe and redirects the pc. Optionally it provides a JTAG debug halt/resume handshake that drains the pipe before freezing it.

Parameters:
FLUSH_CYCLES, 1, cycles flush_o is held after a trap is accepted; legal range 1..7.
DRAIN_CYCLES, 4, cycles fetch is frozen while younger stages drain before halt; legal range 1..15.

Ports:
clk_i  input  1  clock
n_rst_i  input  1  asynchronous active-low reset
stallreq_if_i  input  1  fetch stage stall request
stallreq_id_i  input  1  decode stage stall request (load-use hazard)
stallreq_ex_i  input  1  execute stage stall request (multi-cycle mul/div)
stallreq_mem_i  input  1  memory stage stall request (bus wait)
trap_req_i  input  1  trap/interrupt/mret request; level, held until trap_ack_o
trap_pc_i  input  32  target pc for the trap
dbg_halt_req_i  input  1  debug halt request; level
dbg_resume_req_i  input  1  debug resume request; level
stall_o  output  6  stall vector: bit0 pc, bit1 if, bit2 id, bit3 ex, bit4 mem, bit5 wb; 1 = Stop
flush_o  output  1  flush all pipeline registers to NOP
ctrl_redirect_pc_o  output  1  one-cycle pc redirect strobe
redirect_pc_o  output  32  redirect target
trap_ack_o  output  1  one-cycle trap acceptance pulse
dbg_halted_o  output  1  core is halted

Behaviour:
- Reset (async, n_rst_i = 0):
  - state = RUN; all counters = 0.
  - stall_o = 6'b000000; flush_o = 0; ctrl_redirect_pc_o = 0.
  - redirect_pc_o = 32'h0; trap_ack_o = 0; dbg_halted_o = 0.
  - Reset mid-operation aborts any FLUSH, DRAIN or HALTED state immediately.
- States: RUN, FLUSH, DRAIN, HALTED. State is registered.
- RUN stall_o is combinational from the requests, by priority:
  - mem -> 6'b011111
  - else ex -> 6'b001111
  - else id -> 6'b000111
  - else if -> 6'b000011
  - else 6'b000000
- RUN trap acceptance:
  - Condition: trap_req_i = 1 and stallreq_mem_i = 0.
  - In that same cycle N: trap_ack_o = 1 (combinational); trap_pc_i is latched into redirect_pc_o at the clock edge; next state = FLUSH.
  - If stallreq_mem_i = 1, the trap waits with no ack.
- FLUSH:
  - Lasts FLUSH_CYCLES cycles (N+1 .. N+FLUSH_CYCLES), with flush_o = 1 and stall_o = 0.
  - ctrl_redirect_pc_o = 1 only in cycle N+1.
  - After the last cycle the state returns to RUN.
  - Stall requests and a new trap_req_i are ignored (not acked) in this state.
- redirect_pc_o holds the last latched value until the next trap is accepted.
- RUN halt (DEBUG_HALT_EN only):
  - dbg_halt_req_i = 1 with no acceptable trap -> DRAIN, counter loaded with DRAIN_CYCLES.
  - Trap and halt in the same cycle: the trap wins; halt stays pending because it is a level.
- DRAIN:
  - stall_o = 6'b000011 (pc and if frozen, younger stages advance); counter decrements each cycle.
  - If stallreq_mem_i = 1, stall_o follows the RUN priority vector and the counter holds.
  - If trap_req_i = 1 and stallreq_mem_i = 0: ack the trap and go to FLUSH (drain abandoned). After FLUSH, RUN re-evaluates the halt request.
  - Counter reaching 0 -> HALTED.
- HALTED:
  - stall_o = 6'b111111; dbg_halted_o = 1, registered, asserted from the first HALTED cycle.
  - trap_req_i is ignored (not acked).
  - dbg_resume_req_i = 1 -> RUN; dbg_halted_o = 0 and stall_o follows the requests from the next cycle.
  - If halt and resume are both high in HALTED, resume wins.
- Counter widths: 3 bits for flush, 4 bits for drain. There is no wrap-around, because each counter is loaded only on entry.

Optional Feature:
- Macro: PIPE_CTRL_DEBUG_HALT_EN.
- Defined: DRAIN and HALTED states exist and the debug handshake behaves as described above.
- Undefined:
  - The dbg_* inputs remain as ports but are ignored.
  - dbg_halted_o is tied to 0.
  - The state machine is RUN/FLUSH only.

Test Plan:
- Priority: stallreq_id_i = 1 and stallreq_ex_i = 1 together -> stall_o = 6'b001111 the same cycle. Then stallreq_mem_i = 1 as well -> 6'b011111.
- Trap, FLUSH_CYCLES = 1: trap_req_i = 1 with trap_pc_i = 32'h0000_0100 in cycle N -> trap_ack_o = 1 in N. In N+1: flush_o = 1, ctrl_redirect_pc_o = 1, redirect_pc_o = 32'h100. In N+2: back to RUN with all three strobes at 0.
- Trap blocked: trap_req_i = 1 with stallreq_mem_i = 1 for 3 cycles -> no ack and stall_o = 6'b011111. Ack occurs in the first cycle after stallreq_mem_i drops.
- Halt (macro on, DRAIN_CYCLES = 4): dbg_halt_req_i = 1 in cycle N -> stall_o = 6'b000011 for N+1..N+4. Then stall_o = 6'b111111 and dbg_halted_o = 1 at N+5. Resume pulse -> RUN the next cycle.
- Trap and halt together in RUN: trap acked, FLUSH runs, then DRAIN begins. A trap raised again during DRAIN is acked and the drain is abandoned.
- Reset mid-FLUSH with FLUSH_CYCLES = 3: assert n_rst_i = 0 in the 2nd FLUSH cycle -> flush_o = 0 and redirect_pc_o = 0 immediately, without waiting for a clock; state = RUN after release.
